uart_frame_scheduler: RTL and testbench

- Shares the single uart_controller TX byte channel between three requesters: execution-status reports, segment notifications and a host byte FIFO.
- Round-robin arbitration selects one requester; the block serialises its data into a checksummed frame and drives the tx_enable/tx_data/tx_busy handshake byte by byte.
- Sits between the top-level status logic / executor segment interface and uart_controller.

---
 rtl/uart_frame_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_uart_frame_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_scheduler.sv
// Round-robin scheduler: status reports, segment words and host FIFO bytes share one UART TX channel.
// Each grant is framed as AA TYPE LEN payload CHK and handed over byte by byte via tx_enable/tx_busy.
`timescale 1ns/1ps
module uart_frame_scheduler #(
  parameter int HOST_FIFO_DEPTH  = 16,
  parameter int HOST_MAX_PAYLOAD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        status_evt,
  input  logic [31:0] status_pc,
  input  logic [31:0] status_cycles,
  input  logic        segment_ready,
  input  logic [31:0] segment_data,
  output logic        segment_ack,
  input  logic        host_wr_en,
  input  logic [7:0]  host_wr_data,
  output logic        host_full,
  output logic        host_overflow,
  output logic        tx_enable,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        sched_busy,
  output logic [15:0] frames_sent,
  output logic [7:0]  status_dropped
);

  localparam int AW = (HOST_FIFO_DEPTH > 1) ? $clog2(HOST_FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [1:0] SRC_STATUS = 2'd0;
  localparam logic [1:0] SRC_SEG    = 2'd1;
  localparam logic [1:0] SRC_HOST   = 2'd2;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [HOST_FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          pend_q, pend_d;
  logic [63:0]   snap_q, snap_d, pay_q, pay_d;
  logic [7:0]    drop_q, drop_d, len_q, len_d, chk_q, chk_d;
  logic [1:0]    rr_q, rr_d, src_q, src_d, tmo_q, tmo_d;
  logic [8:0]    idx_q, idx_d;
  logic [15:0]   frames_q, frames_d;

  logic [2:0]    elig;
  logic          grant_vld, status_grant;
  logic [1:0]    grant_src, cand;
  logic [7:0]    host_len, grant_len, grant_type, type_byte, cur_byte;
  logic [8:0]    last_idx;
  logic          is_pay, push, pop;

  assign host_full  = (cnt_q == CW'(HOST_FIFO_DEPTH));
  assign elig       = {cnt_q != '0, segment_ready, pend_q};
  assign host_len   = (cnt_q > CW'(HOST_MAX_PAYLOAD)) ? 8'(HOST_MAX_PAYLOAD) : 8'(cnt_q);
  assign last_idx   = {1'b0, len_q} + 9'd3;
  assign is_pay     = (idx_q >= 9'd3) && (idx_q < last_idx);
  assign type_byte  = {6'd0, src_q} + 8'd1;
  assign grant_type = {6'd0, grant_src} + 8'd1;

  // Scan offsets from the far end so the requester closest to rr_q wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_src = rr_q;
    cand      = rr_q;
    for (int k = 2; k >= 0; k--) begin
      cand = 2'((int'(rr_q) + k) % 3);
      if (elig[cand]) begin
        grant_vld = 1'b1;
        grant_src = cand;
      end
    end
  end

  always_comb begin
    grant_len = host_len;
    if (grant_src == SRC_STATUS)   grant_len = 8'd8;
    else if (grant_src == SRC_SEG) grant_len = 8'd4;
  end

  always_comb begin
    cur_byte = chk_q;
    if (idx_q == 9'd0)      cur_byte = 8'hAA;
    else if (idx_q == 9'd1) cur_byte = type_byte;
    else if (idx_q == 9'd2) cur_byte = len_q;
    else if (is_pay)        cur_byte = (src_q == SRC_HOST) ? mem_q[rptr_q] : pay_q[63:56];
  end

  assign tx_enable    = (state_q == SEND) && !tx_busy;
  assign tx_data      = tx_enable ? cur_byte : 8'h00;
  assign segment_ack  = (state_q == IDLE) && grant_vld && (grant_src == SRC_SEG);
  assign status_grant = (state_q == IDLE) && grant_vld && (grant_src == SRC_STATUS);
  assign pop          = tx_enable && is_pay && (src_q == SRC_HOST);
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign push         = host_wr_en && (!host_full || pop);

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    ovf_d    = ovf_q | (host_wr_en & ~push);
    pend_d   = pend_q;
    snap_d   = snap_q;
    drop_d   = drop_q;
    pay_d    = pay_q;
    len_d    = len_q;
    chk_d    = chk_q;
    rr_d     = rr_q;
    src_d    = src_q;
    tmo_d    = tmo_q;
    idx_d    = idx_q;
    frames_d = frames_q;

    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;

    // The in-flight frame works from pay_q, so snap_q is free to take a new event.
    if (status_evt) begin
      snap_d = {status_pc, status_cycles};
      pend_d = 1'b1;
      if (pend_q && !status_grant && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end else if (status_grant) begin
      pend_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d = SEND;
          src_d   = grant_src;
          rr_d    = (grant_src == SRC_HOST) ? SRC_STATUS : grant_src + 2'd1;
          idx_d   = 9'd0;
          tmo_d   = 2'd0;
          len_d   = grant_len;
          chk_d   = grant_type ^ grant_len;
          if (grant_src == SRC_STATUS)   pay_d = snap_q;
          else if (grant_src == SRC_SEG) pay_d = {segment_data, 32'h0};
        end
      end
      SEND: begin
        if (!tx_busy) begin
          state_d = WAIT_ACK;
          tmo_d   = 2'd0;
          if (is_pay) begin
            chk_d = chk_q ^ cur_byte;
            pay_d = {pay_q[55:0], 8'h00};
          end
        end
      end
      WAIT_ACK: begin
        if (tx_busy || tmo_q == 2'd3) state_d = WAIT_DONE;
        else                          tmo_d   = tmo_q + 2'd1;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (idx_q == last_idx) begin
            state_d  = IDLE;
            frames_d = frames_q + 16'd1;
          end else begin
            state_d = SEND;
            idx_d   = idx_q + 9'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= host_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      pend_q   <= 1'b0;
      snap_q   <= '0;
      drop_q   <= '0;
      pay_q    <= '0;
      len_q    <= '0;
      chk_q    <= '0;
      rr_q     <= SRC_STATUS;
      src_q    <= SRC_STATUS;
      tmo_q    <= '0;
      idx_q    <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      pend_q   <= pend_d;
      snap_q   <= snap_d;
      drop_q   <= drop_d;
      pay_q    <= pay_d;
      len_q    <= len_d;
      chk_q    <= chk_d;
      rr_q     <= rr_d;
      src_q    <= src_d;
      tmo_q    <= tmo_d;
      idx_q    <= idx_d;
      frames_q <= frames_d;
    end
  end

  assign host_overflow  = ovf_q;
  assign sched_busy     = (state_q != IDLE);
  assign frames_sent    = frames_q;
  assign status_dropped = drop_q;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Bench for uart_frame_scheduler: emulated UART handshake, byte capture and a frame-level scoreboard.
`timescale 1ns/1ps
module tb_uart_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        status_evt, segment_ready, host_wr_en, tx_busy;
  logic [31:0] status_pc, status_cycles, segment_data;
  logic [7:0]  host_wr_data, tx_data, status_dropped;
  logic        segment_ack, host_full, host_overflow, tx_enable, sched_busy;
  logic [15:0] frames_sent;

  uart_frame_scheduler #(.HOST_FIFO_DEPTH(16), .HOST_MAX_PAYLOAD(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .status_evt(status_evt), .status_pc(status_pc), .status_cycles(status_cycles),
    .segment_ready(segment_ready), .segment_data(segment_data), .segment_ack(segment_ack),
    .host_wr_en(host_wr_en), .host_wr_data(host_wr_data),
    .host_full(host_full), .host_overflow(host_overflow),
    .tx_enable(tx_enable), .tx_data(tx_data), .tx_busy(tx_busy),
    .sched_busy(sched_busy), .frames_sent(frames_sent), .status_dropped(status_dropped)
  );

  always #5 clk = ~clk;

  int         n_asrt = 0, n_fail = 0;
  int         exp_frames = 0, exp_acks = 0, exp_drop = 0;
  int         rd_idx = 0, ack_cnt = 0, ph = 0, cnt = 0;
  logic       force_busy = 1'b0;
  logic [7:0] cap[$];
  logic [7:0] exp_pay[$];
  logic [7:0] host_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // UART stand-in: random accept latency, random busy length, occasional silent accept.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin tx_busy = 1'b0; ph = 0; end
      else if (force_busy) tx_busy = 1'b1;
      else if (ph == 1) begin
        if (cnt == 0) begin tx_busy = 1'b1; ph = 2; cnt = $urandom_range(1, 3); end
        else cnt--;
      end else if (ph == 2) begin
        cnt--;
        if (cnt == 0) begin tx_busy = 1'b0; ph = 0; end
      end else tx_busy = 1'b0;
      #2;
      if (tx_enable) begin
        cap.push_back(tx_data);
        if ($urandom_range(0, 3) == 0) ph = 0;
        else begin ph = 1; cnt = $urandom_range(0, 2); end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (segment_ack) ack_cnt++;
    end
  end

  task automatic status_pulse(input logic [31:0] pc, input logic [31:0] cyc);
    status_pc = pc; status_cycles = cyc; status_evt = 1'b1;
    @(negedge clk);
    status_evt = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit keep);
    host_wr_en = 1'b1; host_wr_data = b;
    if (keep) host_q.push_back(b);
    @(negedge clk);
    host_wr_en = 1'b0;
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_pay.push_back(8'(w >> (8 * i)));
  endtask

  task automatic wait_busy(input string tag);
    for (int i = 0; i < 20 && !sched_busy; i++) @(negedge clk);
    chk({tag, "_busy"}, 64'(sched_busy), 64'(1));
  endtask

  task automatic seg_wait(input string tag);
    int a0 = ack_cnt;
    for (int i = 0; i < 3000 && ack_cnt == a0; i++) @(negedge clk);
    chk({tag, "_ack"}, 64'(ack_cnt - a0), 64'(1));
    segment_ready = 1'b0;
    exp_acks++;
  endtask

  // Expected frame: AA, type, len, exp_pay, XOR of type/len/payload.
  task automatic expect_frame(input logic [7:0] typ, input string tag);
    int         need = exp_pay.size() + 4;
    logic [7:0] x = typ ^ 8'(exp_pay.size());
    bit         ok;
    foreach (exp_pay[i]) x ^= exp_pay[i];
    for (int i = 0; i < 4000 && cap.size() < rd_idx + need; i++) @(negedge clk);
    ok = (cap.size() >= rd_idx + need);
    chk({tag, "_avail"}, 64'(ok), 64'(1));
    if (ok) begin
      chk({tag, "_sync"}, 64'(cap[rd_idx]), 64'(8'hAA));
      chk({tag, "_type"}, 64'(cap[rd_idx + 1]), 64'(typ));
      chk({tag, "_len"}, 64'(cap[rd_idx + 2]), 64'(exp_pay.size()));
      foreach (exp_pay[i]) chk({tag, "_pay"}, 64'(cap[rd_idx + 3 + i]), 64'(exp_pay[i]));
      chk({tag, "_chk"}, 64'(cap[rd_idx + need - 1]), 64'(x));
      rd_idx += need;
    end else rd_idx = cap.size();
    exp_frames++;
    exp_pay.delete();
  endtask

  task automatic expect_host(input int n, input string tag);
    for (int i = 0; i < n; i++) exp_pay.push_back(host_q.pop_front());
    expect_frame(8'h03, tag);
  endtask

  task automatic expect_status(input logic [31:0] pc, input logic [31:0] cyc, input string tag);
    add_word(pc); add_word(cyc);
    expect_frame(8'h01, tag);
  endtask

  task automatic settle(input string tag);
    repeat (30) @(negedge clk);
    chk({tag, "_idle"}, 64'(sched_busy), 64'(0));
    chk({tag, "_nobytes"}, 64'(cap.size()), 64'(rd_idx));
    chk({tag, "_frames"}, 64'(frames_sent), 64'(16'(exp_frames)));
    chk({tag, "_drop"}, 64'(status_dropped), 64'(exp_drop));
    chk({tag, "_acks"}, 64'(ack_cnt), 64'(exp_acks));
    chk({tag, "_full"}, 64'(host_full), 64'(0));
  endtask

  logic [31:0] pa, ca, pb, cb, sd;
  int          n, rem, c, kind;

  initial begin
    rst_n = 1'b1; status_evt = 1'b0; status_pc = '0; status_cycles = '0;
    segment_ready = 1'b0; segment_data = '0; host_wr_en = 1'b0; host_wr_data = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", 64'(sched_busy), 64'(0));
    chk("rst_txen", 64'(tx_enable), 64'(0));
    chk("rst_txdata", 64'(tx_data), 64'(0));
    chk("rst_frames", 64'(frames_sent), 64'(0));
    chk("rst_drop", 64'(status_dropped), 64'(0));
    chk("rst_full", 64'(host_full), 64'(0));
    chk("rst_ovf", 64'(host_overflow), 64'(0));
    chk("rst_ack", 64'(segment_ack), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed status frame.
    status_pulse(32'h0000_1234, 32'h0000_0010);
    expect_status(32'h0000_1234, 32'h0000_0010, "st1");
    settle("st1");

    // Directed segment frame with a single accept pulse.
    segment_data = 32'hDEAD_BEEF; segment_ready = 1'b1;
    seg_wait("seg1");
    add_word(32'hDEAD_BEEF);
    expect_frame(8'h02, "seg1");
    settle("seg1");

    // Ten host bytes queued behind a status frame: split 8 + 2.
    pa = $urandom; ca = $urandom;
    status_pulse(pa, ca);
    wait_busy("h10");
    for (int i = 0; i < 10; i++) push_byte(8'(i), 1'b1);
    expect_status(pa, ca, "h10_st");
    expect_host(8, "h10_a");
    expect_host(2, "h10_b");
    settle("h10");

    // Simultaneous requests while the channel is stalled, plus an overwritten status event.
    force_busy = 1'b1;
    @(negedge clk);
    push_byte(8'h77, 1'b1);
    wait_busy("sim");
    pa = $urandom; ca = $urandom; pb = $urandom; cb = $urandom; sd = $urandom;
    status_pc = pa; status_cycles = ca; status_evt = 1'b1;
    segment_data = sd; segment_ready = 1'b1;
    host_wr_en = 1'b1; host_wr_data = 8'h88; host_q.push_back(8'h88);
    @(negedge clk);
    status_evt = 1'b0; host_wr_en = 1'b0;
    status_pulse(pb, cb);
    exp_drop = 1;
    chk("sim_drop", 64'(status_dropped), 64'(1));
    force_busy = 1'b0;
    seg_wait("sim");
    expect_host(1, "sim_h77");
    expect_status(pb, cb, "sim_st");
    add_word(sd);
    expect_frame(8'h02, "sim_seg");
    expect_host(1, "sim_h88");
    settle("sim");

    // Fill the FIFO past capacity while stalled.
    force_busy = 1'b1;
    @(negedge clk);
    pa = $urandom; ca = $urandom;
    status_pulse(pa, ca);
    wait_busy("ovf");
    for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i), 1'b1);
    chk("ovf_full16", 64'(host_full), 64'(1));
    chk("ovf_clean16", 64'(host_overflow), 64'(0));
    push_byte(8'h50, 1'b0);
    chk("ovf_full17", 64'(host_full), 64'(1));
    chk("ovf_flag", 64'(host_overflow), 64'(1));
    force_busy = 1'b0;
    expect_status(pa, ca, "ovf_st");
    expect_host(8, "ovf_a");
    expect_host(8, "ovf_b");
    settle("ovf");
    chk("ovf_sticky", 64'(host_overflow), 64'(1));

    // Randomized single-requester rounds.
    for (int it = 0; it < 6; it++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        pa = $urandom; ca = $urandom; pb = $urandom; cb = $urandom;
        status_pulse(pa, ca);
        wait_busy("rs");
        n = $urandom_range(0, 1);
        if (n == 1) status_pulse(pb, cb);
        expect_status(pa, ca, "rs_a");
        if (n == 1) expect_status(pb, cb, "rs_shadow");
      end else if (kind == 1) begin
        sd = $urandom;
        segment_data = sd; segment_ready = 1'b1;
        seg_wait("rg");
        add_word(sd);
        expect_frame(8'h02, "rg");
      end else begin
        n = $urandom_range(2, 16);
        force_busy = 1'b1;
        @(negedge clk);
        push_byte(8'($urandom), 1'b1);
        wait_busy("rh");
        for (int i = 1; i < n; i++) push_byte(8'($urandom), 1'b1);
        force_busy = 1'b0;
        expect_host(1, "rh_first");
        rem = n - 1;
        while (rem > 0) begin
          c = (rem > 8) ? 8 : rem;
          expect_host(c, "rh_chunk");
          rem -= c;
        end
      end
      settle("rnd");
    end

    // Reset in the middle of a status payload.
    pa = $urandom; ca = $urandom;
    status_pulse(pa, ca);
    for (int i = 0; i < 400 && cap.size() < rd_idx + 5; i++) @(negedge clk);
    chk("mid_reached", 64'(cap.size() >= rd_idx + 5), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_txen", 64'(tx_enable), 64'(0));
    chk("mid_busy", 64'(sched_busy), 64'(0));
    chk("mid_frames", 64'(frames_sent), 64'(0));
    chk("mid_drop", 64'(status_dropped), 64'(0));
    chk("mid_ovf", 64'(host_overflow), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rd_idx = cap.size(); exp_frames = 0; exp_drop = 0;
    @(negedge clk);
    pa = $urandom; ca = $urandom;
    status_pulse(pa, ca);
    expect_status(pa, ca, "post_rst");
    settle("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
